imem_fill: RTL and testbench

Line-fill responder on the instruction-side bus. Accepts a cache-line read request from the L1 instruction cache (`b_rd_i`/`b_addr_i`), fetches the line from backing memory as a sequence of narrower beats, and assembles them. It then returns the whole line on `b_data_i` with a one-cycle `b_dv_i` strobe. It sits between the hart's L1 I-cache and the memory/bus arbiter.

---
 rtl/imem_fill.sv | 105 ++++++++++
 tb/tb_imem_fill.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fill.sv
// Line-fill responder: fetches one I-cache line as N memory beats, returns it with a 1-cycle b_dv_i pulse.
// Latency N+1 cycles at zero wait, +1 per stalled m_ack cycle; m_req is never withdrawn before its ack.
module imem_fill #(
    parameter int LINE = 256,
    parameter int BEAT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     b_addr_i,
    input  logic            b_rd_i,
    output logic [LINE-1:0] b_data_i,
    output logic            b_dv_i,
    output logic [63:0]     m_addr,
    output logic            m_req,
    input  logic            m_ack,
    input  logic [BEAT-1:0] m_data
);
    localparam int N    = LINE / BEAT;
    localparam int OFFS = $clog2(LINE / 8);
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [63:0]   BASE_MASK = ~((64'd1 << OFFS) - 64'd1);
    localparam logic [63:0]   STEP      = 64'(BEAT / 8);
    localparam logic [CW-1:0] LAST      = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          abort, abort_nxt;
    logic [63:0]   m_addr_nxt;
    logic          m_req_nxt;
    logic          b_dv_nxt;
    logic          beat_we;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        abort_nxt  = abort;
        m_addr_nxt = m_addr;
        m_req_nxt  = m_req;
        b_dv_nxt   = 1'b0;
        beat_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (b_rd_i) begin
                    m_addr_nxt = b_addr_i & BASE_MASK;
                    m_req_nxt  = 1'b1;
                    cnt_nxt    = '0;
                    abort_nxt  = 1'b0;
                    state_nxt  = FILL;
                end
            end
            FILL: begin
                if (!b_rd_i) begin
                    abort_nxt = 1'b1;
                end
                // The outstanding beat must complete even when the requester has gone away.
                if (m_ack) begin
                    beat_we = 1'b1;
                    if (abort || !b_rd_i) begin
                        m_req_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else if (cnt == LAST) begin
                        m_req_nxt = 1'b0;
                        b_dv_nxt  = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt    = cnt + CW'(1);
                        m_addr_nxt = m_addr + STEP;
                    end
                end
            end
            RESP: begin
                // b_rd_i is still high here; ignoring it avoids a duplicate fill.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            abort    <= 1'b0;
            m_addr   <= '0;
            m_req    <= 1'b0;
            b_dv_i   <= 1'b0;
            b_data_i <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            abort  <= abort_nxt;
            m_addr <= m_addr_nxt;
            m_req  <= m_req_nxt;
            b_dv_i <= b_dv_nxt;
            if (beat_we) begin
                b_data_i[cnt*BEAT +: BEAT] <= m_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_fill.sv
// Bench for imem_fill: directed scenarios plus randomized fills, aborts and resets
// checked against a cycle-schedule model derived from per-beat wait counts.
module tb_imem_fill;
    localparam int LINE = 256;
    localparam int BEAT = 64;
    localparam int NB   = LINE / BEAT;
    localparam int BB   = BEAT / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [63:0]     b_addr_i;
    logic            b_rd_i;
    logic [LINE-1:0] b_data_i;
    logic            b_dv_i;
    logic [63:0]     m_addr;
    logic            m_req;
    logic            m_ack;
    logic [BEAT-1:0] m_data;

    int checks = 0;
    int errors = 0;
    logic [BEAT-1:0] bd [NB];

    imem_fill #(.LINE(LINE), .BEAT(BEAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .b_addr_i (b_addr_i),
        .b_rd_i   (b_rd_i),
        .b_data_i (b_data_i),
        .b_dv_i   (b_dv_i),
        .m_addr   (m_addr),
        .m_req    (m_req),
        .m_ack    (m_ack),
        .m_data   (m_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input int c, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        b_rd_i = 1'b0;
        m_ack  = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk1("idle_dv", i, b_dv_i, 1'b0);
            chk1("idle_req", i, m_req, 1'b0);
        end
    endtask

    // Beat k is acked in cycle t[k] = sum over j<=k of (1 + w[j]); line valid the cycle after the last ack.
    task automatic run_fill(input logic [63:0] addr, input int w0, input int w1, input int w2, input int w3,
                            input int abort_at, input int rst_at,
                            input logic alt_en, input logic [63:0] alt_addr);
        int w [NB];
        int t [NB];
        int acc, k_a, req_end, dv_cyc, stop, kcur;
        logic exp_req, exp_ack;
        logic [63:0] base;
        logic [LINE-1:0] line;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        base = addr & ~64'(LINE / 8 - 1);
        acc = 0;
        for (int k = 0; k < NB; k++) begin
            acc += 1 + w[k];
            t[k] = acc;
            line[k*BEAT +: BEAT] = bd[k];
        end
        k_a = NB - 1;
        if (abort_at > 0)
            for (int k = NB - 1; k >= 0; k--)
                if (t[k] >= abort_at) k_a = k;
        req_end = t[k_a];
        dv_cyc  = (abort_at > 0 || rst_at > 0) ? -1 : t[NB-1] + 1;
        if (rst_at > 0)        stop = rst_at + 1;
        else if (abort_at > 0) stop = req_end + 1;
        else                   stop = dv_cyc;

        step();
        chk1("c0_req", 0, m_req, 1'b0);
        chk1("c0_dv", 0, b_dv_i, 1'b0);
        b_rd_i   = 1'b1;
        b_addr_i = addr;
        m_ack    = 1'b0;
        for (int c = 1; c <= stop; c++) begin
            step();
            if (rst_at > 0 && c == rst_at + 1) begin
                rst_n  = 1'b1;
                b_rd_i = 1'b0;
                m_ack  = 1'b0;
                chk1("rst_req", c, m_req, 1'b0);
                chk1("rst_dv", c, b_dv_i, 1'b0);
                chkl("rst_data", c, b_data_i, '0);
                chk64("rst_addr", c, m_addr, 64'd0);
            end else begin
                exp_req = (c <= req_end);
                kcur = 0;
                for (int k = NB - 1; k >= 0; k--)
                    if (t[k] >= c) kcur = k;
                chk1("req", c, m_req, exp_req);
                if (exp_req) chk64("addr", c, m_addr, base + 64'(BB * kcur));
                chk1("dv", c, b_dv_i, c == dv_cyc);
                if (c == dv_cyc) chkl("line", c, b_data_i, line);
                exp_ack = exp_req && (c == t[kcur]);
                m_ack   = exp_ack;
                m_data  = exp_ack ? bd[kcur] : {$urandom(), $urandom()};
                if (alt_en && c == 2) b_addr_i = alt_addr;
                if (c == abort_at) b_rd_i = 1'b0;
                if (c == rst_at) rst_n = 1'b0;
            end
        end
    endtask

    task automatic rand_beats();
        for (int k = 0; k < NB; k++) bd[k] = {$urandom(), $urandom()};
    endtask

    initial begin
        logic [LINE-1:0] ref_line;
        int w [NB];
        int total, mode;
        logic [63:0] ra;

        rst_n = 1'b0; b_rd_i = 1'b0; b_addr_i = '0; m_ack = 1'b0; m_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("rst_idle_dv", i, b_dv_i, 1'b0);
            chk1("rst_idle_req", i, m_req, 1'b0);
            chkl("rst_idle_data", i, b_data_i, '0);
            chk64("rst_idle_addr", i, m_addr, 64'd0);
        end

        // Zero-wait fill with the arithmetic beat pattern.
        for (int k = 0; k < NB; k++) bd[k] = 64'(64'h1111_1111_1111_1111 * 64'(k + 1));
        run_fill(64'h1000_0034, 0, 0, 0, 0, 0, 0, 1'b0, 64'd0);
        idle(2);
        ref_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        chkl("line_const", 0, b_data_i, ref_line);

        // Two wait states on beat 1.
        rand_beats();
        run_fill(64'h1000_0034, 0, 2, 0, 0, 0, 0, 1'b0, 64'd0);
        idle(2);

        // Abort while the beat 1 ack is stalled, then a clean fill.
        rand_beats();
        run_fill(64'h1000_0034, 0, 3, 0, 0, 2, 0, 1'b0, 64'd0);
        idle(3);
        rand_beats();
        run_fill(64'h2000_0000, 0, 0, 0, 0, 0, 0, 1'b0, 64'd0);
        idle(2);

        // Address change mid-fill is ignored.
        rand_beats();
        run_fill(64'h3000_0040, 0, 1, 0, 0, 0, 0, 1'b1, 64'h5000_0000);
        idle(2);

        // Back-to-back requests.
        rand_beats();
        run_fill(64'h40, 0, 0, 0, 0, 0, 0, 1'b0, 64'd0);
        rand_beats();
        run_fill(64'h80, 0, 0, 0, 0, 0, 0, 1'b0, 64'd0);
        idle(2);

        // Reset in cycle 3 of a fill, then recovery.
        rand_beats();
        run_fill(64'h6000_0000, 0, 1, 0, 0, 0, 3, 1'b0, 64'd0);
        idle(2);
        rand_beats();
        run_fill(64'h6000_0100, 0, 0, 0, 0, 0, 0, 1'b0, 64'd0);
        idle(1);

        // Randomized fills, aborts and resets.
        for (int it = 0; it < 40; it++) begin
            rand_beats();
            total = 0;
            for (int k = 0; k < NB; k++) begin
                w[k] = $urandom_range(0, 3);
                total += 1 + w[k];
            end
            ra   = {$urandom(), $urandom()};
            mode = $urandom_range(0, 5);
            if (mode == 4) begin
                run_fill(ra, w[0], w[1], w[2], w[3], $urandom_range(1, total), 0, 1'b0, 64'd0);
                idle(1);
            end else if (mode == 5) begin
                run_fill(ra, w[0], w[1], w[2], w[3], 0, $urandom_range(1, total), 1'b0, 64'd0);
                idle(1);
            end else begin
                run_fill(ra, w[0], w[1], w[2], w[3], 0, 0, mode[0], {$urandom(), $urandom()});
                if (mode > 1) idle($urandom_range(1, 3));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
